// File: rtl/mdu_defs_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes, FSM states,
// default latencies and the signed-division helper.
package mdu_defs_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Divides magnitudes so 0x80000000 / -1 wraps to 0x80000000 rem 0 without
  // relying on simulator behaviour for signed overflow. Returns {rem, quo}.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    a_neg = a[31];
    b_neg = b[31];
    a_mag = a_neg ? (32'd0 - a) : a;
    b_mag = b_neg ? (32'd0 - b) : b;
    if (b_mag == 32'd0) b_mag = 32'd1;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;
    return {rem, quo};
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit holding architectural HI/LO with modelled latency.
// Optional feature: MDU_CANCEL_EN enables aborting an in-flight op via cancel.
//
// state  | meaning
// S_IDLE | no op in flight; MT* writes and new MULT/DIV launches accepted
// S_RUN  | MULT/DIV in flight, busy high, result held in pend until cnt hits 0
module mult_div_unit
  import mdu_defs_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_hi,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

`ifdef MDU_CANCEL_EN
  localparam logic CANCEL_EN = 1'b1;
`else
  localparam logic CANCEL_EN = 1'b0;
`endif

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [63:0]       pend_q, pend_d;

  logic              cancel_act;
  logic [63:0]       prod_s;
  logic [63:0]       prod_u;
  logic [63:0]       div_s;
  logic [63:0]       div_u;
  logic [31:0]       rt_safe;

  assign cancel_act = CANCEL_EN & cancel;

  always_comb begin
    prod_s  = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u  = {32'd0, rs_val} * {32'd0, rt_val};
    rt_safe = (rt_val == 32'd0) ? 32'd1 : rt_val;
    div_u   = {rs_val % rt_safe, rs_val / rt_safe};
    div_s   = div_signed(rs_val, rt_val);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel_act) begin
          case (md_op_e'(md_op))
            OP_MULT, OP_MULTU: begin
              pend_d  = (md_op_e'(md_op) == OP_MULT) ? prod_s : prod_u;
              state_d = S_RUN;
              busy_d  = 1'b1;
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor still occupies the unit but commits the old HI/LO.
              if (rt_val == 32'd0) pend_d = {hi_q, lo_q};
              else                 pend_d = (md_op_e'(md_op) == OP_DIV) ? div_s : div_u;
              state_d = S_RUN;
              busy_d  = 1'b1;
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cancel_act) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  assign busy   = busy_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign md_out = rd_hi ? hi_q : lo_q;

endmodule
